// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues single outstanding word
// requests to instruction memory and buffers returned {pc, instruction} pairs
// in a circular prefetch queue consumed by the decoder.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [31:0] RESET_ADDR = RESET_PC & ~32'h3;

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t          state, state_next;
  logic [31:0]     fetch_pc, fetch_pc_next;
  logic            req_next;
  logic [31:0]     addr_next;
  logic [31:0]     target;
  logic [31:0]     redir_pc;

  logic [31:0]     q_pc   [DEPTH];
  logic [31:0]     q_data [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count, count_next;

  logic            ack, pop, push, slot_free;

  assign redir_pc = redirect_pc & ~32'h3;
  assign ack      = imem_req & imem_ack;
  assign pop      = inst_valid & inst_ready;
  assign push     = (state == REQ) & ack & ~redirect;

  assign inst_valid = (count != '0);
  assign inst_data  = q_data[rd_ptr];
  assign inst_pc    = q_pc[rd_ptr];

  // Queue occupancy after this cycle's push/pop; a redirect empties it.
  always_comb begin
    count_next = count;
    if (redirect) count_next = '0;
    else          count_next = count + CW'(push) - CW'(pop);
  end

  // A request is only launched when its returning word is guaranteed a slot.
  assign slot_free = (count_next < CW'(DEPTH));

  // Fetch FSM next-state and registered request outputs.
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    req_next      = imem_req;
    addr_next     = imem_addr;
    target        = fetch_pc;
    case (state)
      IDLE: begin
        target        = redirect ? redir_pc : fetch_pc;
        fetch_pc_next = target;
        if (slot_free) begin
          state_next = REQ;
          req_next   = 1'b1;
          addr_next  = target;
        end
      end
      REQ: begin
        if (ack) begin
          target        = redirect ? redir_pc : imem_addr + 32'd4;
          fetch_pc_next = target;
          if (slot_free) begin
            req_next  = 1'b1;
            addr_next = target;
          end else begin
            state_next = IDLE;
            req_next   = 1'b0;
          end
        end else if (redirect) begin
          state_next    = DISCARD;
          fetch_pc_next = redir_pc;
        end
      end
      DISCARD: begin
        target        = redirect ? redir_pc : fetch_pc;
        fetch_pc_next = target;
        if (ack) begin
          if (slot_free) begin
            state_next = REQ;
            req_next   = 1'b1;
            addr_next  = target;
          end else begin
            state_next = IDLE;
            req_next   = 1'b0;
          end
        end
      end
      default: begin
        state_next = IDLE;
        req_next   = 1'b0;
      end
    endcase
  end

  // Fetch FSM state, fetch PC and request registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      fetch_pc  <= RESET_ADDR;
      imem_req  <= 1'b0;
      imem_addr <= RESET_ADDR;
    end else begin
      state     <= state_next;
      fetch_pc  <= fetch_pc_next;
      imem_req  <= req_next;
      imem_addr <= addr_next;
    end
  end

  // Prefetch queue storage and pointers; redirect flush wins over push.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_pc[i]   <= '0;
        q_data[i] <= '0;
      end
    end else begin
      count <= count_next;
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          q_pc[wr_ptr]   <= imem_addr;
          q_data[wr_ptr] <= imem_rdata;
          wr_ptr         <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a combinational memory model.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  int n_assert = 0;
  int n_fail   = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_data   (inst_data),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    imem_ack    = 1'b0;
    inst_ready  = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_req",   {31'd0, imem_req},   32'd0);
    chk("rst_addr",  imem_addr,           32'h0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_data",  inst_data,           32'h0);
    chk("rst_pc",    inst_pc,             32'h0);

    // Streaming: ack high, core always ready
    do_reset();
    imem_ack   = 1'b1;
    inst_ready = 1'b1;
    step();
    chk("s_req0",   {31'd0, imem_req},   32'd1);
    chk("s_addr0",  imem_addr,           32'h0);
    chk("s_valid0", {31'd0, inst_valid}, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("s_addr",  imem_addr,           32'(4 * i));
      chk("s_valid", {31'd0, inst_valid}, 32'd1);
      chk("s_pc",    inst_pc,             32'(4 * (i - 1)));
      chk("s_data",  inst_data,           mem_word(32'(4 * (i - 1))));
    end

    // Fill: ack high, core stalled
    do_reset();
    imem_ack = 1'b1;
    step();
    chk("f_addr0", imem_addr, 32'h0);
    step(); step(); step();
    chk("f_addr3", imem_addr, 32'hC);
    step();
    chk("f_req_full",  {31'd0, imem_req}, 32'd0);
    chk("f_head_pc",   inst_pc,           32'h0);
    step();
    chk("f_req_hold",  {31'd0, imem_req}, 32'd0);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("f_req_resume", {31'd0, imem_req}, 32'd1);
    chk("f_addr_10",    imem_addr,         32'h10);
    chk("f_head_pc4",   inst_pc,           32'h4);
    step();
    chk("f_req_single", {31'd0, imem_req}, 32'd0);
    chk("f_head_pc4b",  inst_pc,           32'h4);
    step();
    chk("f_req_idle",   {31'd0, imem_req}, 32'd0);

    // Redirect while waiting for a slow ack
    do_reset();
    inst_ready = 1'b1;
    step();
    chk("d_addr_a", imem_addr, 32'h0);
    step();
    chk("d_req_w1", {31'd0, imem_req}, 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    chk("d_addr_hold",  imem_addr,           32'h0);
    chk("d_req_hold",   {31'd0, imem_req},   32'd1);
    imem_ack = 1'b1;
    step();
    chk("d_addr_tgt",   imem_addr,           32'h100);
    chk("d_dropped",    {31'd0, inst_valid}, 32'd0);
    step();
    chk("d_valid",      {31'd0, inst_valid}, 32'd1);
    chk("d_pc",         inst_pc,             32'h100);
    chk("d_data",       inst_data,           mem_word(32'h100));

    // Redirect with 3 queued, same cycle as pop and ack
    do_reset();
    imem_ack = 1'b1;
    step(); step(); step(); step();
    chk("r_addr_c", imem_addr, 32'hC);
    chk("r_head",   inst_pc,   32'h0);
    inst_ready  = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h203;
    step();
    redirect = 1'b0;
    imem_ack = 1'b0;
    chk("r_flush",  {31'd0, inst_valid}, 32'd0);
    chk("r_addr",   imem_addr,           32'h200);
    chk("r_req",    {31'd0, imem_req},   32'd1);
    imem_ack = 1'b1;
    step();
    chk("r_pc",     inst_pc,             32'h200);
    chk("r_data",   inst_data,           mem_word(32'h200));
    step();
    chk("r_pc2",    inst_pc,             32'h204);

    // PC wrap at the top of the address space
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect = 1'b0;
    chk("w_flush", {31'd0, inst_valid}, 32'd0);
    chk("w_addr0", imem_addr,           32'hFFFF_FFF8);
    step();
    chk("w_pc0",   inst_pc,   32'hFFFF_FFF8);
    chk("w_addr1", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("w_pc1",   inst_pc,   32'hFFFF_FFFC);
    chk("w_addr2", imem_addr, 32'h0);
    step();
    chk("w_pc2",   inst_pc,   32'h0);
    chk("w_data2", inst_data, mem_word(32'h0));
    chk("w_addr3", imem_addr, 32'h4);

    // Asynchronous reset while a request waits for ack
    imem_ack = 1'b0;
    step();
    step();
    chk("a_req_wait", {31'd0, imem_req}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("a_req",   {31'd0, imem_req},   32'd0);
    chk("a_addr",  imem_addr,           32'h0);
    chk("a_valid", {31'd0, inst_valid}, 32'd0);
    chk("a_pc",    inst_pc,             32'h0);
    chk("a_data",  inst_data,           32'h0);
    step();
    reset_n  = 1'b1;
    imem_ack = 1'b1;
    step();
    chk("a_req_rel",  {31'd0, imem_req}, 32'd1);
    chk("a_addr_rel", imem_addr,         32'h0);
    step();
    chk("a_pc_rel",   inst_pc,           32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the instruction decoder and register-read logic of the MIPS core. Owns the fetch PC, issues word requests to a variable-latency instruction memory over a req/ack handshake, and buffers returned words with their PCs in a small prefetch queue. The core consumes `{pc, instruction}` pairs over a valid/ready handshake and redirects fetch on taken branches, `jal`, and `jr`.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `DEPTH`, 4: prefetch queue entries; power of 2, at least 2.
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  memory request valid (registered).
- `imem_addr`  out  32  request word address; bits [1:0] always 00 (registered).
- `imem_ack`  in  1  memory accepts the request and returns `imem_rdata` in the same cycle.
- `imem_rdata`  in  32  instruction word; sampled only when `imem_req && imem_ack`.
- `inst_valid`  out  1  queue head valid.
- `inst_data`  out  32  queue head instruction.
- `inst_pc`  out  32  PC of queue head instruction.
- `inst_ready`  in  1  core accepts head; pop when `inst_valid && inst_ready`.
- `redirect`  in  1  one-cycle pulse: flush and refetch from `redirect_pc`.
- `redirect_pc`  in  32  new fetch target; bits [1:0] ignored, treated as 00.

## Operation
- Reset values: `imem_req`=0, `imem_addr`=RESET_PC, `inst_valid`=0, `inst_data`=0, `inst_pc`=0, queue count 0, fetch PC RESET_PC, state IDLE.
- At most one outstanding request. `imem_req`/`imem_addr` are held stable from assertion until the ack cycle.
- Queue: circular, rd/wr pointers `log2(DEPTH)` bits wrapping modulo DEPTH, count 0..DEPTH. Push and pop in the same cycle leave count unchanged. `inst_*` driven from the head entry.
- Slot reservation: a new request is issued only if the count after this cycle's push/pop is < DEPTH, so every returned word has a slot.
- States:
  - IDLE: no request outstanding. If a slot is free, go to REQ with `imem_addr`=fetch PC.
  - REQ: request outstanding.
    - Ack without redirect: push `{imem_addr, imem_rdata}`; fetch PC = `imem_addr`+4. Stay in REQ with the new address if a slot is free, else go to IDLE.
    - Ack with redirect: drop data; fetch PC = redirect_pc. Go to REQ with `redirect_pc` if a slot is free, else IDLE.
    - Redirect without ack: go to DISCARD; record fetch PC = redirect_pc.
  - DISCARD: keep the request stable until ack, then drop the data. A further redirect overwrites the recorded target. On ack, go to REQ with the recorded target (or IDLE if no slot).
- Redirect flush: queue cleared at the edge (count 0, pointers 0), regardless of state. An accepted pop in the redirect cycle is consumed, not replayed. Redirect overrides any push that cycle.
- PC arithmetic: 32-bit modulo. 32'hFFFF_FFFC+4 wraps to 0 with no flag.

## Timing
- Zero-wait memory (ack in the request cycle): one request, and one instruction, per cycle sustained while the core pops every cycle.
- Ack at edge t: the entry is visible on `inst_*` after edge t (`inst_valid` high in cycle t+1 if the queue was empty).
- Redirect at cycle t in IDLE or REQ-with-ack: `imem_req` with the redirect PC from cycle t+1. In REQ without ack: the target is requested the cycle after the ack.
- After reset release, `imem_req` rises the first cycle after the first edge (IDLE->REQ).
- Full queue with `inst_ready`=0: `imem_req` low, fetch PC frozen. Fetch resumes the cycle after the first pop.
- Asserting `reset_n` low mid-request drops everything immediately; the memory is reset by the same signal.

## Test plan
- Reset release, ack tied high, `inst_ready` high: `imem_addr` runs 0,4,8,C,…; `inst_pc`/`inst_data` follow one cycle behind, one per cycle, no gaps.
- Ack tied high, `inst_ready` low: exactly 4 entries (PCs 0,4,8,C) and then `imem_req` drops. Raise `inst_ready` one cycle -> pops PC 0, then a single request for 0x10 follows.
- Ack delayed 3 cycles, redirect to 0x100 in the 2nd wait cycle: address 0x0 held until ack, its data not pushed, next request 0x100, first `inst_pc`=0x100.
- Redirect to 0x203 with 3 entries queued, in the same cycle as a pop and an ack: `inst_valid` low the next cycle, next request 0x200, popped entry not re-presented, acked word dropped.
- Fetch from 0xFFFF_FFF8: PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Pull `reset_n` low while REQ is waiting for ack: outputs go to reset values immediately. After release, the first request is at RESET_PC.
